// File: rtl/pic_host_bus_sequencer.sv
// CPU-side bus initiator for an 8259A PIC: runs the ICW1..ICW4 initialisation
// write sequence and single OCW writes / status reads with programmable timing.
module pic_host_bus_sequencer #(
    parameter int SETUP_CYCLES  = 1,
    parameter int STROBE_CYCLES = 2,
    parameter int HOLD_CYCLES   = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       init_start,
    input  logic [7:0] icw1_val,
    input  logic [7:0] icw2_val,
    input  logic [7:0] icw3_val,
    input  logic [7:0] icw4_val,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic       req_a0,
    input  logic [7:0] req_data,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       busy,
    output logic       init_done,
    output logic       CS_bar,
    output logic       RD_bar,
    output logic       WR_bar,
    output logic       A0,
    output logic [7:0] data_bus_out,
    output logic       data_bus_oe,
    input  logic [7:0] data_bus_in
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_RECOVER
    } state_t;

    typedef enum logic [1:0] {
        STEP_ICW1,
        STEP_ICW2,
        STEP_ICW3,
        STEP_ICW4
    } step_t;

    localparam logic [3:0] SETUP_LOAD  = 4'(SETUP_CYCLES - 1);
    localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYCLES - 1);
    localparam logic [3:0] HOLD_LOAD   = 4'(HOLD_CYCLES - 1);

    state_t     state_q;
    step_t      step_q;
    logic [3:0] cnt_q;
    logic       init_active_q;
    logic       write_q;
    logic       ready_q;
    logic [7:0] icw1_q;
    logic [7:0] icw2_q;
    logic [7:0] icw3_q;
    logic [7:0] icw4_q;

    logic       cs_bar_q;
    logic       rd_bar_q;
    logic       wr_bar_q;
    logic       a0_q;
    logic [7:0] dout_q;
    logic       oe_q;
    logic [7:0] rd_data_q;
    logic       rd_valid_q;
    logic       init_done_q;

    step_t      step_d;
    logic       step_more_d;
    logic       step_a0_d;
    logic [7:0] step_data_d;

    logic       launch_d;
    logic       launch_write_d;
    logic       launch_a0_d;
    logic [7:0] launch_data_d;

    // Next init step after the current one; ICW3 and ICW4 are optional.
    always_comb begin
        step_more_d = 1'b0;
        step_d      = step_q;
        case (step_q)
            STEP_ICW1: begin
                step_more_d = 1'b1;
                step_d      = STEP_ICW2;
            end
            STEP_ICW2: begin
                if (!icw1_q[1]) begin
                    step_more_d = 1'b1;
                    step_d      = STEP_ICW3;
                end else if (icw1_q[0]) begin
                    step_more_d = 1'b1;
                    step_d      = STEP_ICW4;
                end
            end
            STEP_ICW3: begin
                if (icw1_q[0]) begin
                    step_more_d = 1'b1;
                    step_d      = STEP_ICW4;
                end
            end
            default: begin
                step_more_d = 1'b0;
                step_d      = step_q;
            end
        endcase
    end

    always_comb begin
        step_a0_d   = 1'b1;
        step_data_d = icw2_q;
        case (step_d)
            STEP_ICW1: begin
                step_a0_d   = 1'b0;
                step_data_d = icw1_q;
            end
            STEP_ICW2: step_data_d = icw2_q;
            STEP_ICW3: step_data_d = icw3_q;
            default:   step_data_d = icw4_q;
        endcase
    end

    // Transaction launch: from IDLE (init beats a request) or back-to-back init steps.
    always_comb begin
        launch_d       = 1'b0;
        launch_write_d = 1'b1;
        launch_a0_d    = 1'b0;
        launch_data_d  = 8'h00;
        if (state_q == ST_IDLE) begin
            if (init_start) begin
                launch_d       = 1'b1;
                launch_write_d = 1'b1;
                launch_a0_d    = 1'b0;
                launch_data_d  = icw1_val | 8'h10;
            end else if (req_valid) begin
                launch_d       = 1'b1;
                launch_write_d = req_write;
                launch_a0_d    = req_a0;
                launch_data_d  = req_write ? req_data : 8'h00;
            end
        end else if (state_q == ST_RECOVER && init_active_q && step_more_d) begin
            launch_d       = 1'b1;
            launch_write_d = 1'b1;
            launch_a0_d    = step_a0_d;
            launch_data_d  = step_data_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            step_q        <= STEP_ICW1;
            cnt_q         <= 4'd0;
            init_active_q <= 1'b0;
            write_q       <= 1'b0;
            ready_q       <= 1'b0;
            icw1_q        <= 8'h00;
            icw2_q        <= 8'h00;
            icw3_q        <= 8'h00;
            icw4_q        <= 8'h00;
            cs_bar_q      <= 1'b1;
            rd_bar_q      <= 1'b1;
            wr_bar_q      <= 1'b1;
            a0_q          <= 1'b0;
            dout_q        <= 8'h00;
            oe_q          <= 1'b0;
            rd_data_q     <= 8'h00;
            rd_valid_q    <= 1'b0;
            init_done_q   <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;

            if (launch_d) begin
                state_q  <= ST_SETUP;
                cnt_q    <= SETUP_LOAD;
                write_q  <= launch_write_d;
                ready_q  <= 1'b0;
                cs_bar_q <= 1'b0;
                a0_q     <= launch_a0_d;
                dout_q   <= launch_data_d;
                oe_q     <= launch_write_d;
            end

            case (state_q)
                ST_IDLE: begin
                    if (init_start) begin
                        step_q        <= STEP_ICW1;
                        init_active_q <= 1'b1;
                        init_done_q   <= 1'b0;
                        icw1_q        <= icw1_val | 8'h10;
                        icw2_q        <= icw2_val;
                        icw3_q        <= icw3_val;
                        icw4_q        <= icw4_val;
                    end else if (req_valid) begin
                        init_active_q <= 1'b0;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        state_q  <= ST_STROBE;
                        cnt_q    <= STROBE_LOAD;
                        wr_bar_q <= ~write_q;
                        rd_bar_q <= write_q;
                    end
                end
                ST_STROBE: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        state_q  <= ST_HOLD;
                        cnt_q    <= HOLD_LOAD;
                        wr_bar_q <= 1'b1;
                        rd_bar_q <= 1'b1;
                        if (!write_q) begin
                            rd_data_q  <= data_bus_in;
                            rd_valid_q <= 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        state_q  <= ST_RECOVER;
                        cs_bar_q <= 1'b1;
                        oe_q     <= 1'b0;
                    end
                end
                ST_RECOVER: begin
                    if (launch_d) begin
                        step_q <= step_d;
                    end else begin
                        state_q <= ST_IDLE;
                        ready_q <= 1'b1;
                        if (init_active_q) begin
                            init_done_q   <= 1'b1;
                            init_active_q <= 1'b0;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready    = ready_q & ~init_start;
    assign busy         = (state_q != ST_IDLE);
    assign init_done    = init_done_q;
    assign rd_data      = rd_data_q;
    assign rd_valid     = rd_valid_q;
    assign CS_bar       = cs_bar_q;
    assign RD_bar       = rd_bar_q;
    assign WR_bar       = wr_bar_q;
    assign A0           = a0_q;
    assign data_bus_out = dout_q;
    assign data_bus_oe  = oe_q;

endmodule

// File: tb/tb_pic_host_bus_sequencer.sv
// Self-checking bench: a bus monitor records each CS_bar-low transaction and
// compares it with sequences derived from the ICW/OCW rules.
`timescale 1ns/1ps
module tb_pic_host_bus_sequencer;

    localparam int SU      = 1;
    localparam int SB      = 2;
    localparam int HO      = 1;
    localparam int TXN_LEN = SU + SB + HO + 1;

    typedef struct packed {
        logic       wr;
        logic       rd;
        logic       a0;
        logic       oe;
        logic [7:0] data;
        logic [3:0] setup;
        logic [3:0] strobe;
        logic [3:0] hold;
        logic       stable;
    } txn_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       init_start = 1'b0;
    logic [7:0] icw1_val = 8'h00, icw2_val = 8'h00, icw3_val = 8'h00, icw4_val = 8'h00;
    logic       req_valid = 1'b0, req_write = 1'b0, req_a0 = 1'b0;
    logic [7:0] req_data = 8'h00;
    logic       req_ready, rd_valid, busy, init_done;
    logic       CS_bar, RD_bar, WR_bar, A0, data_bus_oe;
    logic [7:0] rd_data, data_bus_out, data_bus_in;
    logic [7:0] pic_rd_val = 8'h00;

    int tests_run = 0;
    int tests_failed = 0;

    txn_t       obs_q[$];
    logic [8:0] rdv_q[$];
    txn_t       cur;
    logic       in_txn = 1'b0;
    int         stray_cnt = 0;

    always #5 clk = ~clk;

    // PIC model: drives status only while RD_bar is low.
    assign data_bus_in = RD_bar ? 8'hFF : pic_rd_val;

    pic_host_bus_sequencer #(
        .SETUP_CYCLES (SU),
        .STROBE_CYCLES(SB),
        .HOLD_CYCLES  (HO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .init_start  (init_start),
        .icw1_val    (icw1_val),
        .icw2_val    (icw2_val),
        .icw3_val    (icw3_val),
        .icw4_val    (icw4_val),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_a0      (req_a0),
        .req_data    (req_data),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .busy        (busy),
        .init_done   (init_done),
        .CS_bar      (CS_bar),
        .RD_bar      (RD_bar),
        .WR_bar      (WR_bar),
        .A0          (A0),
        .data_bus_out(data_bus_out),
        .data_bus_oe (data_bus_oe),
        .data_bus_in (data_bus_in)
    );

    always @(negedge clk) begin
        if (reset) begin
            in_txn = 1'b0;
        end else begin
            if (CS_bar && (!WR_bar || !RD_bar || data_bus_oe)) stray_cnt++;
            if (rd_valid) rdv_q.push_back({!CS_bar && RD_bar && WR_bar, rd_data});
            if (!CS_bar) begin
                if (!in_txn) begin
                    in_txn     = 1'b1;
                    cur        = '0;
                    cur.a0     = A0;
                    cur.oe     = data_bus_oe;
                    cur.data   = data_bus_oe ? data_bus_out : 8'h00;
                    cur.stable = 1'b1;
                end
                if (A0 !== cur.a0 || data_bus_oe !== cur.oe ||
                    (cur.oe && data_bus_out !== cur.data) || (!WR_bar && !RD_bar))
                    cur.stable = 1'b0;
                if (!WR_bar || !RD_bar) begin
                    if (cur.hold != 4'd0) cur.stable = 1'b0;
                    if (!WR_bar) cur.wr = 1'b1;
                    if (!RD_bar) cur.rd = 1'b1;
                    cur.strobe = cur.strobe + 4'd1;
                end else if (cur.strobe == 4'd0) begin
                    cur.setup = cur.setup + 4'd1;
                end else begin
                    cur.hold = cur.hold + 4'd1;
                end
            end else if (in_txn) begin
                in_txn = 1'b0;
                obs_q.push_back(cur);
            end
        end
    end

    function automatic txn_t mk_txn(input logic wr, input logic a0, input logic [7:0] d);
        txn_t t;
        t.wr = wr; t.rd = ~wr; t.a0 = a0; t.oe = wr; t.data = wr ? d : 8'h00;
        t.setup = 4'(SU); t.strobe = 4'(SB); t.hold = 4'(HO); t.stable = 1'b1;
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        tests_run++;
        if ({CS_bar, RD_bar, WR_bar, data_bus_oe, init_done, busy, req_ready, rd_valid} !== 8'b1110_0000) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %b want 11100000",
                     {CS_bar, RD_bar, WR_bar, data_bus_oe, init_done, busy, req_ready, rd_valid});
        end
        tests_run++;
        if ({A0, data_bus_out, rd_data} !== 17'h0) begin
            tests_failed++;
            $display("FAIL reset_data: got %h want 0", {A0, data_bus_out, rd_data});
        end
        reset = 1'b0;
        tick();
        tests_run++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release: ready=%b busy=%b want ready=1 busy=0", req_ready, busy);
        end
        $display("[TB] reset: done");
    endtask

    task automatic test_init(input string name, input logic [7:0] i1, input logic [7:0] i2,
                             input logic [7:0] i3, input logic [7:0] i4);
        txn_t exp_q[$];
        int   n;
        exp_q.push_back(mk_txn(1'b1, 1'b0, i1 | 8'h10));
        exp_q.push_back(mk_txn(1'b1, 1'b1, i2));
        if (!i1[1]) exp_q.push_back(mk_txn(1'b1, 1'b1, i3));
        if (i1[0])  exp_q.push_back(mk_txn(1'b1, 1'b1, i4));
        obs_q.delete();
        icw1_val = i1; icw2_val = i2; icw3_val = i3; icw4_val = i4;
        init_start = 1'b1;
        #1;
        tests_run++;
        if (req_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_ready_during_start: got %b want 0", name, req_ready);
        end
        tick();
        init_start = 1'b0;
        icw1_val = 8'($urandom); icw2_val = 8'($urandom);
        icw3_val = 8'($urandom); icw4_val = 8'($urandom);
        tests_run++;
        if (init_done !== 1'b0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s_accept: init_done=%b busy=%b want 0/1", name, init_done, busy);
        end
        n = 0;
        while (!init_done && n < 200) begin
            tick();
            n++;
        end
        tests_run++;
        if (n !== TXN_LEN * exp_q.size() || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_done_latency: got %0d cycles busy=%b want %0d cycles busy=0",
                     name, n, busy, TXN_LEN * exp_q.size());
        end
        tests_run++;
        if (obs_q.size() !== exp_q.size()) begin
            tests_failed++;
            $display("FAIL %s_write_count: got %0d want %0d", name, obs_q.size(), exp_q.size());
        end else begin
            for (int k = 0; k < exp_q.size(); k++) begin
                tests_run++;
                if (obs_q[k] !== exp_q[k]) begin
                    tests_failed++;
                    $display("FAIL %s_write%0d: got %h want %h", name, k, obs_q[k], exp_q[k]);
                end
            end
        end
        $display("[TB] init %s icw1=%h: %0d writes, %0d cycles", name, i1, obs_q.size(), n);
    endtask

    task automatic test_init_modes();
        test_init("single_icw4", 8'h13, 8'h20, 8'hAA, 8'h01);
        test_init("cascade_no_icw4", 8'h00, 8'h48, 8'h04, 8'h77);
        test_init("single_no_icw4", 8'h12, 8'h30, 8'h55, 8'h0F);
        test_init("cascade_icw4", 8'h01, 8'h08, 8'hF0, 8'h03);
        for (int r = 0; r < 6; r++)
            test_init("random", 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    endtask

    task automatic test_requests();
        txn_t       exp_q[$];
        logic [8:0] exp_rd[$];
        logic       w, a;
        logic [7:0] d, pv;
        int         n;
        obs_q.delete();
        rdv_q.delete();
        for (int i = 0; i < 12; i++) begin
            if (i == 0) begin
                w = 1'b0; a = 1'b0; d = 8'h00; pv = 8'h5A;
            end else begin
                w = 1'($urandom); a = 1'($urandom); d = 8'($urandom); pv = 8'($urandom);
            end
            n = 0;
            while (!req_ready && n < 50) begin
                tick();
                n++;
            end
            tests_run++;
            if (req_ready !== 1'b1) begin
                tests_failed++;
                $display("FAIL req%0d_ready_timeout: got %b want 1", i, req_ready);
            end
            pic_rd_val = pv;
            req_valid = 1'b1; req_write = w; req_a0 = a; req_data = d;
            tick();
            req_valid = 1'b0;
            req_write = 1'($urandom); req_a0 = 1'($urandom); req_data = 8'($urandom);
            exp_q.push_back(mk_txn(w, a, d));
            if (!w) exp_rd.push_back({1'b1, pv});
            if (i == 1) begin
                init_start = 1'b1;
                tick();
                init_start = 1'b0;
            end
            $display("[TB] req%0d %s a0=%b data=%h", i, w ? "write" : "read ", a, w ? d : pv);
        end
        n = 0;
        while (busy && n < 50) begin
            tick();
            n++;
        end
        tick();
        tests_run++;
        if (obs_q.size() !== exp_q.size()) begin
            tests_failed++;
            $display("FAIL req_txn_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end else begin
            for (int k = 0; k < exp_q.size(); k++) begin
                tests_run++;
                if (obs_q[k] !== exp_q[k]) begin
                    tests_failed++;
                    $display("FAIL req_txn%0d: got %h want %h", k, obs_q[k], exp_q[k]);
                end
            end
        end
        tests_run++;
        if (rdv_q.size() !== exp_rd.size()) begin
            tests_failed++;
            $display("FAIL rd_valid_pulses: got %0d want %0d", rdv_q.size(), exp_rd.size());
        end else begin
            for (int k = 0; k < exp_rd.size(); k++) begin
                tests_run++;
                if (rdv_q[k] !== exp_rd[k]) begin
                    tests_failed++;
                    $display("FAIL rd_data%0d: got %h want %h", k, rdv_q[k], exp_rd[k]);
                end
            end
        end
        tests_run++;
        if (init_done !== 1'b1) begin
            tests_failed++;
            $display("FAIL init_start_while_busy: init_done=%b want 1", init_done);
        end
    endtask

    task automatic test_same_cycle();
        txn_t exp_q[$];
        int   n;
        exp_q.push_back(mk_txn(1'b1, 1'b0, 8'h13));
        exp_q.push_back(mk_txn(1'b1, 1'b1, 8'h20));
        exp_q.push_back(mk_txn(1'b1, 1'b1, 8'h01));
        exp_q.push_back(mk_txn(1'b1, 1'b0, 8'h20));
        obs_q.delete();
        icw1_val = 8'h13; icw2_val = 8'h20; icw3_val = 8'hCC; icw4_val = 8'h01;
        init_start = 1'b1;
        req_valid = 1'b1; req_write = 1'b1; req_a0 = 1'b0; req_data = 8'h20;
        #1;
        tests_run++;
        if (req_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL same_cycle_ready: got %b want 0", req_ready);
        end
        tick();
        init_start = 1'b0;
        n = 0;
        while (!req_ready && n < 100) begin
            tick();
            n++;
        end
        tests_run++;
        if (n !== 3 * TXN_LEN || init_done !== 1'b1) begin
            tests_failed++;
            $display("FAIL same_cycle_ready_rise: got %0d cycles init_done=%b want %0d/1",
                     n, init_done, 3 * TXN_LEN);
        end
        tick();
        req_valid = 1'b0;
        tests_run++;
        if ({CS_bar, WR_bar, A0, data_bus_oe, data_bus_out} !== {4'b0101, 8'h20}) begin
            tests_failed++;
            $display("FAIL same_cycle_ocw_start: got %h want %h",
                     {CS_bar, WR_bar, A0, data_bus_oe, data_bus_out}, {4'b0101, 8'h20});
        end
        n = 0;
        while (busy && n < 50) begin
            tick();
            n++;
        end
        tick();
        tests_run++;
        if (obs_q.size() !== exp_q.size()) begin
            tests_failed++;
            $display("FAIL same_cycle_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end else begin
            for (int k = 0; k < exp_q.size(); k++) begin
                tests_run++;
                if (obs_q[k] !== exp_q[k]) begin
                    tests_failed++;
                    $display("FAIL same_cycle_txn%0d: got %h want %h", k, obs_q[k], exp_q[k]);
                end
            end
        end
        $display("[TB] same-cycle init+ocw: %0d transactions", obs_q.size());
    endtask

    task automatic test_reset_mid();
        obs_q.delete();
        icw1_val = 8'h13; icw2_val = 8'h20; icw3_val = 8'h00; icw4_val = 8'h01;
        init_start = 1'b1;
        tick();
        init_start = 1'b0;
        repeat (7) tick();
        #2;
        tests_run++;
        if ({CS_bar, WR_bar, A0, data_bus_out} !== {3'b001, 8'h20}) begin
            tests_failed++;
            $display("FAIL reset_mid_pre: got %h want %h", {CS_bar, WR_bar, A0, data_bus_out}, {3'b001, 8'h20});
        end
        reset = 1'b1;
        #1;
        tests_run++;
        if ({WR_bar, CS_bar, data_bus_oe, RD_bar, busy, init_done} !== 6'b110100) begin
            tests_failed++;
            $display("FAIL reset_mid_async: got %b want 110100",
                     {WR_bar, CS_bar, data_bus_oe, RD_bar, busy, init_done});
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (40) tick();
        tests_run++;
        if (obs_q.size() !== 1 || init_done !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_mid_after: txns=%0d init_done=%b busy=%b ready=%b want 1/0/0/1",
                     obs_q.size(), init_done, busy, req_ready);
        end
        $display("[TB] reset mid-ICW2: %0d complete writes seen", obs_q.size());
    endtask

    task automatic test_bus_protocol();
        tests_run++;
        if (stray_cnt !== 0) begin
            tests_failed++;
            $display("FAIL bus_idle_activity: got %0d cycles want 0", stray_cnt);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_init_modes();
        test_requests();
        test_same_cycle();
        test_reset_mid();
        test_bus_protocol();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
